// File: rtl/host_cmd_queue.sv
// host_cmd_queue: host-to-commandBuffer command FIFO. Issue is paced by gpuBusy
// and a fixed gap, and read-back data for layer-header reads is captured for the host.
module host_cmd_queue #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int ISSUE_GAP = 2,
  parameter int READ_LAT  = 2
) (
  input  logic              gpuClock,
  input  logic              reset,
  input  logic              hostWrite,
  input  logic [15:0]       hostCmd,
  input  logic [15:0]       hostData,
  output logic              hostFull,
  output logic [ADDR_W:0]   hostCount,
  output logic              hostOverflow,
  input  logic              gpuBusy,
  input  logic [15:0]       dataFromGpu,
  output logic [15:0]       interfaceCmd,
  output logic [15:0]       interfaceData,
  output logic [15:0]       hostReadData,
  output logic              hostReadValid
);

  localparam int GAP_W = (ISSUE_GAP < 2) ? 1 : $clog2(ISSUE_GAP + 1);
  localparam logic [ADDR_W:0]  FULL_COUNT  = (ADDR_W + 1)'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD    = GAP_W'(ISSUE_GAP);
  localparam logic [6:0]       READ_OPCODE = 7'b0100100;

  typedef enum logic {S_WAIT, S_GAP} state_t;

  state_t              state, state_next;
  logic [GAP_W-1:0]    gap_cnt, gap_next;
  logic [31:0]         mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count;
  logic                full, push, pop, tag_in;
  logic [31:0]         head;
  logic [15:0]         cmd_next, data_next;
  logic [READ_LAT-1:0] read_tag;

  // Fullness comes from the registered count, so a same-cycle pop never makes room.
  assign full      = (count == FULL_COUNT);
  assign push      = hostWrite && !full;
  assign head      = mem[rd_ptr];
  assign tag_in    = pop && (head[31:25] == READ_OPCODE);
  assign hostFull  = full;
  assign hostCount = count;

  // NOTE: storage carries no reset; validity is defined solely by pointers and count.
  always_ff @(posedge gpuClock) begin
    if (push) mem[wr_ptr] <= {hostCmd, hostData};
  end

  // NOTE: clocked blocks use <= so every register updates from pre-edge values.
  always_ff @(posedge gpuClock) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      hostOverflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
      if (hostWrite && full) hostOverflow <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    pop        = 1'b0;
    cmd_next   = '0;
    data_next  = '0;
    unique case (state)
      S_WAIT: begin
        if (count != '0 && !gpuBusy) begin
          pop                   = 1'b1;
          {cmd_next, data_next} = head;
          gap_next              = GAP_LOAD;
          state_next            = S_GAP;
        end
      end
      S_GAP: begin
        gap_next = gap_cnt - GAP_W'(1);
        if (gap_cnt == GAP_W'(1)) state_next = S_WAIT;
      end
      default: state_next = S_WAIT;
    endcase
  end

  always_ff @(posedge gpuClock) begin
    if (!reset) begin
      state         <= S_WAIT;
      gap_cnt       <= '0;
      interfaceCmd  <= '0;
      interfaceData <= '0;
      read_tag      <= '0;
      hostReadData  <= '0;
      hostReadValid <= 1'b0;
    end else begin
      state         <= state_next;
      gap_cnt       <= gap_next;
      interfaceCmd  <= cmd_next;
      interfaceData <= data_next;
      // Tag enters on the pop edge and exits READ_LAT edges later, when the data is valid.
      read_tag      <= (read_tag << 1) | READ_LAT'(tag_in);
      hostReadValid <= read_tag[READ_LAT-1];
      if (read_tag[READ_LAT-1]) hostReadData <= dataFromGpu;
    end
  end

endmodule

// File: tb/tb_host_cmd_queue.sv
// Directed bench for host_cmd_queue: reset, pacing, stall, overflow, read-back, wrap.
module tb_host_cmd_queue;

  logic        gpuClock = 1'b0;
  logic        reset = 1'b0;
  logic        hostWrite = 1'b0;
  logic [15:0] hostCmd = '0;
  logic [15:0] hostData = '0;
  logic        hostFull;
  logic [4:0]  hostCount;
  logic        hostOverflow;
  logic        gpuBusy = 1'b0;
  logic [15:0] dataFromGpu = '0;
  logic [15:0] interfaceCmd;
  logic [15:0] interfaceData;
  logic [15:0] hostReadData;
  logic        hostReadValid;

  int checks = 0;
  int errors = 0;

  host_cmd_queue dut (
    .gpuClock      (gpuClock),
    .reset         (reset),
    .hostWrite     (hostWrite),
    .hostCmd       (hostCmd),
    .hostData      (hostData),
    .hostFull      (hostFull),
    .hostCount     (hostCount),
    .hostOverflow  (hostOverflow),
    .gpuBusy       (gpuBusy),
    .dataFromGpu   (dataFromGpu),
    .interfaceCmd  (interfaceCmd),
    .interfaceData (interfaceData),
    .hostReadData  (hostReadData),
    .hostReadValid (hostReadValid)
  );

  always #5 gpuClock = ~gpuClock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge gpuClock);
    #1;
  endtask

  task automatic push(input logic [15:0] c, input logic [15:0] d);
    hostWrite = 1'b1;
    hostCmd   = c;
    hostData  = d;
    tick();
    hostWrite = 1'b0;
  endtask

  initial begin
    logic        seen;
    logic [31:0] exp_q[$];
    logic [31:0] exp_word;
    int          pushed;
    int          got;

    // Reset held for three edges while the host keeps writing.
    hostWrite = 1'b1; hostCmd = 16'h4805; hostData = 16'h1111;
    repeat (3) tick();
    check("rst_count",    32'(hostCount), 32'd0);
    check("rst_full",     32'(hostFull), 32'd0);
    check("rst_overflow", 32'(hostOverflow), 32'd0);
    check("rst_cmd",      32'(interfaceCmd), 32'd0);
    check("rst_data",     32'(interfaceData), 32'd0);
    check("rst_rdata",    32'(hostReadData), 32'd0);
    check("rst_rvalid",   32'(hostReadValid), 32'd0);
    reset = 1'b1; hostWrite = 1'b0;

    // Single issue: one bus cycle, then two NOP cycles.
    push(16'h0005, 16'hABCD);
    check("single_count_after_write", 32'(hostCount), 32'd1);
    check("single_cmd_before_issue", 32'(interfaceCmd), 32'd0);
    tick();
    check("single_issue", {interfaceCmd, interfaceData}, 32'h0005_ABCD);
    check("single_count_after_pop", 32'(hostCount), 32'd0);
    tick();
    check("single_gap1", {interfaceCmd, interfaceData}, 32'd0);
    tick();
    check("single_gap2", {interfaceCmd, interfaceData}, 32'd0);

    // Busy stall: nothing leaves while gpuBusy is high.
    gpuBusy = 1'b1;
    push(16'h0011, 16'h0001);
    push(16'h0022, 16'h0002);
    push(16'h0033, 16'h0003);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (interfaceCmd != 16'h0) seen = 1'b1;
    end
    check("stall_no_issue", 32'(seen), 32'd0);
    check("stall_count", 32'(hostCount), 32'd3);
    gpuBusy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("stall_issue", {interfaceCmd, interfaceData}, {16'(i * 16'h0011), 16'(i)});
      tick();
      check("stall_gap1", 32'(interfaceCmd), 32'd0);
      tick();
      check("stall_gap2", 32'(interfaceCmd), 32'd0);
    end
    check("stall_drained", 32'(hostCount), 32'd0);

    // Overflow: 16 fit, the 17th is dropped; a pop on the same edge frees no room.
    gpuBusy = 1'b1;
    for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i), 16'(i));
    check("ovf_full", 32'(hostFull), 32'd1);
    check("ovf_count", 32'(hostCount), 32'd16);
    check("ovf_flag_clear", 32'(hostOverflow), 32'd0);
    push(16'h01FF, 16'hDEAD);
    check("ovf_flag_set", 32'(hostOverflow), 32'd1);
    check("ovf_count_held", 32'(hostCount), 32'd16);
    gpuBusy = 1'b0;
    push(16'h01EE, 16'hBEEF);
    check("ovf_first_issue", {interfaceCmd, interfaceData}, 32'h0100_0000);
    check("ovf_no_room_on_pop", 32'(hostCount), 32'd15);
    tick(); tick();
    for (int i = 1; i < 16; i++) begin
      tick();
      check("ovf_drain", {interfaceCmd, interfaceData}, {16'h0100 + 16'(i), 16'(i)});
      tick(); tick();
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (interfaceCmd != 16'h0) seen = 1'b1;
    end
    check("ovf_dropped_never_issued", 32'(seen), 32'd0);
    check("ovf_sticky", 32'(hostOverflow), 32'd1);
    check("ovf_empty", 32'(hostCount), 32'd0);

    // Read return: data sampled two edges after the issue edge.
    dataFromGpu = 16'hEEEE;
    push(16'h4805, 16'h0000);
    tick();
    check("read_issue", 32'(interfaceCmd), 32'h4805);
    check("read_valid_e0", 32'(hostReadValid), 32'd0);
    tick();
    check("read_valid_e1", 32'(hostReadValid), 32'd0);
    dataFromGpu = 16'h1234;
    tick();
    check("read_valid_pulse", 32'(hostReadValid), 32'd1);
    check("read_data", 32'(hostReadData), 32'h1234);
    dataFromGpu = 16'hEEEE;
    tick();
    check("read_valid_end", 32'(hostReadValid), 32'd0);
    check("read_data_hold", 32'(hostReadData), 32'h1234);

    // Non-read command: no pulse, data held.
    push(16'h8805, 16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (hostReadValid) seen = 1'b1;
    end
    check("nonread_no_pulse", 32'(seen), 32'd0);
    check("nonread_data_hold", 32'(hostReadData), 32'h1234);

    // Wrap: 40 entries streamed through, including pushes coinciding with pops.
    pushed = 0;
    got    = 0;
    for (int cyc = 0; cyc < 300 && got < 40; cyc++) begin
      if (pushed < 40 && ((cyc % 3 == 1) || (cyc % 3 == 0 && cyc < 30))) begin
        hostWrite = 1'b1;
        hostCmd   = 16'h0200 + 16'(pushed);
        hostData  = ~hostCmd;
        exp_q.push_back({hostCmd, hostData});
        pushed++;
      end else begin
        hostWrite = 1'b0;
      end
      tick();
      if (interfaceCmd != 16'h0) begin
        exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        check("wrap_order", {interfaceCmd, interfaceData}, exp_word);
        got++;
      end
    end
    hostWrite = 1'b0;
    check("wrap_issued", 32'(got), 32'd40);
    tick(); tick(); tick();
    check("wrap_empty", 32'(hostCount), 32'd0);

    // Reset one edge after a read issue discards the pending read and the FIFO.
    push(16'h4807, 16'h0000);
    push(16'h0009, 16'h0009);
    check("rstmid_issue", 32'(interfaceCmd), 32'h4807);
    check("rstmid_count_before", 32'(hostCount), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    dataFromGpu = 16'h5555;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (hostReadValid || interfaceCmd != 16'h0) seen = 1'b1;
      tick();
    end
    check("rstmid_no_pulse_no_issue", 32'(seen), 32'd0);
    check("rstmid_empty", 32'(hostCount), 32'd0);
    check("rstmid_rdata", 32'(hostReadData), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_cmd_queue.md
# host_cmd_queue

Command queue between the host bus interface and `commandBuffer`. The host writes 16-bit command/data pairs into a DEPTH-entry FIFO. The block issues each pair to `commandBuffer` as a single-cycle word on `interfaceCmd`/`interfaceData`, only while the GPU reports not busy, and drives NOP (zero) on all other cycles. It also captures read-back data for layer-header read commands and returns it to the host with a valid pulse.

## Interface
- DEPTH, 16: FIFO entries; power of two, at least 2.
- ADDR_W, 4: log2(DEPTH).
- ISSUE_GAP, 2: minimum number of NOP cycles after each issued command, so that `gpuBusy` has time to reflect it.
- READ_LAT, 2: cycles from a command appearing on `interfaceCmd` to its `dataFromGpu` being sampled.
- gpuClock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- hostWrite  in  1  one-cycle write strobe.
- hostCmd  in  16  command word.
- hostData  in  16  data word.
- hostFull  out  1  FIFO full (count == DEPTH).
- hostCount  out  ADDR_W+1  current FIFO occupancy.
- hostOverflow  out  1  sticky flag: a write was dropped.
- gpuBusy  in  1  busy flag from `commandBuffer`.
- dataFromGpu  in  16  GPU read data.
- interfaceCmd  out  16  command to `commandBuffer`; 0 = NOP.
- interfaceData  out  16  data to `commandBuffer`.
- hostReadData  out  16  captured read result.
- hostReadValid  out  1  one-cycle pulse when `hostReadData` updates.

## Operation
- **Reset (sampled low at an edge):**
  - FIFO emptied: pointers 0, count 0.
  - Issue state returns to S_WAIT; gap counter 0; read-tag pipeline cleared.
  - All outputs 0: `interfaceCmd`, `interfaceData`, `hostReadData`, `hostReadValid`, `hostOverflow`, `hostCount`.
  - `hostFull` is 0, since it is derived from count.
  - Reset asserted mid-gap or mid-read discards everything; no late `hostReadValid` pulse is produced.
- **Write:**
  - `hostWrite`=1 with count < DEPTH pushes {hostCmd, hostData}.
  - `hostWrite`=1 with count == DEPTH drops the pair and sets `hostOverflow`.
  - The full check uses the registered count. A pop in the same cycle does not make room.
- **Simultaneous push and pop:** both occur; count is unchanged; pointers wrap modulo DEPTH.
- **Issue FSM:**
  - S_WAIT:
    - If count > 0 and `gpuBusy`=0: pop the head, register it onto `interfaceCmd`/`interfaceData`, load gap counter = ISSUE_GAP, go to S_GAP.
    - Otherwise: outputs 0, stay in S_WAIT.
  - S_GAP:
    - `interfaceCmd`/`interfaceData` = 0.
    - Counter decrements each cycle; on reaching 0, go to S_WAIT.
    - `gpuBusy` is ignored in this state.
  - A command therefore appears for exactly one cycle. Back-to-back issues are spaced ISSUE_GAP+1 cycles apart.
  - A queued command whose word is 0 is still popped and issued; it appears as a NOP on the bus but still consumes a gap.
- **Read tagging:**
  - An issued command is a read when bits [15:9] == 7'b0100100 (layer-header read).
  - A READ_LAT-deep shift register carries a read tag alongside each issue.
  - When the tag exits the shift register: `hostReadData` <= `dataFromGpu` and `hostReadValid` <= 1 for one cycle.
  - `hostReadData` holds its value until the next capture.
  - Non-read commands never pulse `hostReadValid`.
- **Update-frame command:** 16'd1 is issued like any other command. The subsequent `gpuBusy` high (two cycles later) stalls S_WAIT until rendering and postrender finish.

## Timing
- Write sampled at edge k → `hostCount` updated after edge k.
- Earliest issue: with the FIFO previously empty, S_WAIT, and `gpuBusy`=0 at edge k+1, the word is on `interfaceCmd` during cycle k+1→k+2.
- `gpuBusy` is sampled only in S_WAIT, at the same edge as the pop.
- Read with the command on the bus after edge e: `dataFromGpu` is sampled at edge e+READ_LAT. `hostReadValid` is high during the cycle after that edge.
- Overlapping reads are possible only if ISSUE_GAP+1 < READ_LAT. The shift register handles this; each read yields its own pulse, in issue order.
- `hostFull` and `hostCount` are registered-count derived, with no combinational path from `hostWrite`.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `hostWrite`=1 → all outputs 0 and `hostCount`=0; after release, the first write gives `hostCount`=1.
- **Single issue:** write {0x0005, 0xABCD} with `gpuBusy`=0 → `interfaceCmd`=0x0005 and `interfaceData`=0xABCD for exactly one cycle, then 0 for 2 cycles; `hostCount` returns to 0.
- **Busy stall:**
  - Queue 3 commands with `gpuBusy`=1 for 20 cycles → no issue; `hostCount`=3.
  - Drop `gpuBusy` → the 3 commands issue in order, each one cycle long, 3 cycles apart.
- **Overflow:** write 17 pairs with `gpuBusy`=1 → `hostFull`=1, `hostCount`=16, `hostOverflow`=1; the 17th pair is never issued.
- **Read return:**
  - Issue 0x4805 (layer 5, register 0) with `dataFromGpu`=0x1234 at edge e+2 → `hostReadValid` pulses once with `hostReadData`=0x1234.
  - Issue 0x8805 → no pulse.
- **Wrap and reset:**
  - Push/pop 40 entries continuously → issue order preserved across pointer wrap.
  - Assert `reset` one cycle after a read issue → no `hostReadValid`; FIFO empty.
